card_shuffler: RTL and testbench
================================

# card_shuffler

Synthesizable, parametrised card-deck shuffler that produces a uniformly drawn permutation of `N_CARDS` card indices. It runs a Fisher–Yates shuffle driven by a configurable Fibonacci LFSR, with rejection sampling on each draw. The block sits between the game controller and the board/display logic: the controller requests a new deal with a start handshake, then reads the shuffled order through an indexed read port. It replaces the simulation-only initial-block shuffle with real clocked behaviour and a reseedable random source.

## Interface
- `N_CARDS`, 20: deck size, ≥2.
- `LFSR_W`, 8: LFSR width, ≥ `IDX_W`.
- `LFSR_TAPS`, 8'hB8: feedback tap mask, width `LFSR_W`.
- `SEED`, 8'hFF: reset/fallback seed, width `LFSR_W`, nonzero.
- Derived: `IDX_W` = $clog2(`N_CARDS`).

- `clk`  in  1  single clock; the block uses only this clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request a shuffle; sampled only in IDLE.
- `use_seed`  in  1  when high with an accepted `start`, load `seed` into the LFSR.
- `seed`  in  `LFSR_W`  user seed; value 0 is replaced by `SEED`.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when the order is final.
- `rd_idx`  in  `IDX_W`  read address.
- `rd_card`  out  `IDX_W`  registered `order[rd_idx]`, valid 1 cycle after the address.

## Operation
- LFSR update: next = {lfsr[LFSR_W-2:0], ^(lfsr & LFSR_TAPS)}.
- The LFSR advances every cycle except the cycle in which it is loaded. It is free-running in IDLE, so unseeded shuffles depend on the timing of `start`.
- FSM states: IDLE, INIT, DRAW, SWAP, DONE.
- IDLE, `start`=1: if `use_seed`, set lfsr ← (`seed`==0 ? `SEED` : `seed`). Go to INIT.
- INIT, 1 cycle: order[k] ← k for all k; i ← `N_CARDS`-1. Go to DRAW.
- DRAW: draw = lfsr[IDX_W-1:0], taken from the current register value.
  - If draw ≤ i: j ← draw, go to SWAP.
  - Otherwise stay in DRAW. The LFSR has already advanced, so the next cycle retries.
- SWAP, 1 cycle: order[i] ↔ order[j]. When j==i the order is unchanged. If i==1, go to DONE; otherwise i ← i-1 and go to DRAW.
- DONE: `done`=1 for one cycle, then go to IDLE.
- `start` outside IDLE is ignored. There is no queueing.
- Reads are legal at any time. During a shuffle they return intermediate contents.

## Timing
- Reset values:
  - state = IDLE
  - `busy` = 0
  - `done` = 0
  - `rd_card` = 0
  - order[k] = k
  - lfsr = `SEED`
  - i = 0, j = 0
- A reset asserted mid-shuffle aborts the shuffle in the next cycle, with all reset values applied.
- Minimum latency: `start` sampled at cycle 0, INIT at cycle 1, first DRAW at cycle 2. The best case takes 2(`N_CARDS`-1) DRAW/SWAP cycles, then `done` rises. For `N_CARDS`=2, `done` is asserted in cycle 4.
- Rejection retries add cycles. The total is data-dependent but deterministic for a given seed.
- `busy` rises in the cycle after `start` is accepted and falls in the cycle after `done`.
- `start` may be held high. A new shuffle begins on the first IDLE cycle that sees it, which is the cycle after DONE.
- `rd_card` has 1-cycle read latency. A read in the same cycle as a SWAP returns the pre-swap value.
- Arithmetic: i and j are `IDX_W` bits. The comparison draw ≤ i is unsigned.

## Structure
- Package `card_pkg` holds:
  - the `N_CARDS` default
  - `IDX_W`
  - the `card_idx_t` typedef (logic [IDX_W-1:0])
  - the FSM state enum
  - the default LFSR taps and seed
- Sub-module `lfsr_gen` is parametrised by width, taps and seed. It has ports for load enable, load value, advance enable and state output. The game's other random consumers reuse it.
- The order array is a flop array, not RAM, because INIT writes every entry in parallel.

## Test plan
- LFSR step check: `N_CARDS`=2, `start` at cycle 0 with `use_seed`=1, `seed`=8'h01.
  - `lfsr_gen` after the load: 0x01 → 0x02 → 0x04 → 0x08 → 0x11.
  - Shuffle result: `done` at cycle 4, final order {1,0}.
- Permutation property: `N_CARDS`=20, 50 random seeds. After each `done`, read indices 0..19. Every value 0..19 must appear exactly once.
- Determinism: two shuffles with the same `seed`=8'h5A must give identical orders. `seed`=8'h00 must give the same order as `seed`=`SEED`.
- Handshake: pulse `start` while `busy`=1. It must be ignored, with exactly one `done`. Holding `start` high must produce back-to-back shuffles, each with a single-cycle `done`.
- Reset mid-shuffle: assert `reset` in the 5th DRAW cycle. In the next cycle `busy`=0, and reading index k returns k. A following seeded `start` must behave identically to a fresh run.
- Read latency: with order final, step `rd_idx` 0..19 one per cycle. Each `rd_card` must equal order[`rd_idx`] from the previous cycle.

Source files
------------

// File: rtl/card_pkg.sv
// rtl/card_pkg.sv - shared types and defaults for the card shuffler
package card_pkg;

    localparam int N_CARDS_DEF = 20;
    localparam int IDX_W       = $clog2(N_CARDS_DEF);
    localparam int LFSR_W_DEF  = 8;

    localparam logic [LFSR_W_DEF-1:0] LFSR_TAPS_DEF = 8'hB8;
    localparam logic [LFSR_W_DEF-1:0] SEED_DEF      = 8'hFF;

    typedef logic [IDX_W-1:0] card_idx_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_DRAW,
        ST_SWAP,
        ST_DONE
    } state_t;

endpackage

// File: rtl/lfsr_gen.sv
// rtl/lfsr_gen.sv - loadable Fibonacci LFSR random source
module lfsr_gen
    import card_pkg::*;
#(
    parameter int               WIDTH = LFSR_W_DEF,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(LFSR_TAPS_DEF),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(SEED_DEF)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             adv_i,
    output logic [WIDTH-1:0] state_o
);

    logic [WIDTH-1:0] state_q;
    logic [WIDTH-1:0] state_d;

    // Shift left, feedback bit is the parity of the tapped bits
    assign state_d = {state_q[WIDTH-2:0], ^(state_q & TAPS)};
    assign state_o = state_q;

    // Load has priority over advance; loading never combines with a step
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= SEED;
        end else if (load_i) begin
            state_q <= load_val_i;
        end else if (adv_i) begin
            state_q <= state_d;
        end
    end

endmodule

// File: rtl/card_shuffler.sv
// rtl/card_shuffler.sv - Fisher-Yates deck shuffler with indexed read port
module card_shuffler
    import card_pkg::*;
#(
    parameter int                N_CARDS   = N_CARDS_DEF,
    parameter int                LFSR_W    = LFSR_W_DEF,
    parameter logic [LFSR_W-1:0] LFSR_TAPS = LFSR_W'(LFSR_TAPS_DEF),
    parameter logic [LFSR_W-1:0] SEED      = LFSR_W'(SEED_DEF),
    localparam int               CARD_W    = $clog2(N_CARDS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              use_seed,
    input  logic [LFSR_W-1:0] seed,
    output logic              busy,
    output logic              done,
    input  logic [CARD_W-1:0] rd_idx,
    output logic [CARD_W-1:0] rd_card
);

    state_t             state_q, state_d;
    logic [CARD_W-1:0]  i_q, i_d;
    logic [CARD_W-1:0]  j_q, j_d;
    logic [CARD_W-1:0]  order_q [N_CARDS];
    logic [CARD_W-1:0]  rd_card_q;
    logic [LFSR_W-1:0]  lfsr_q;
    logic [LFSR_W-1:0]  load_val;
    logic               lfsr_load;
    logic [CARD_W-1:0]  draw;
    logic               unused_lfsr_hi;

    // A zero seed would lock the LFSR, so it falls back to the reset seed
    assign lfsr_load = (state_q == ST_IDLE) && start && use_seed;
    assign load_val  = (seed == '0) ? SEED : seed;

    lfsr_gen #(
        .WIDTH (LFSR_W),
        .TAPS  (LFSR_TAPS),
        .SEED  (SEED)
    ) u_lfsr (
        .clk        (clk),
        .reset      (reset),
        .load_i     (lfsr_load),
        .load_val_i (load_val),
        .adv_i      (1'b1),
        .state_o    (lfsr_q)
    );

    // Only the low bits feed the draw; the rest just widen the period
    assign draw           = lfsr_q[CARD_W-1:0];
    assign unused_lfsr_hi = ^lfsr_q;

    assign busy    = (state_q != ST_IDLE);
    assign done    = (state_q == ST_DONE);
    assign rd_card = rd_card_q;

    // FSM state and shuffle indices
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            i_q     <= '0;
            j_q     <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
        end
    end

    // Next state: draw with rejection until the value lands in 0..i, then swap
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_INIT;
                end
            end
            ST_INIT: begin
                i_d     = CARD_W'(N_CARDS - 1);
                state_d = ST_DRAW;
            end
            ST_DRAW: begin
                if (draw <= i_q) begin
                    j_d     = draw;
                    state_d = ST_SWAP;
                end
            end
            ST_SWAP: begin
                if (i_q == CARD_W'(1)) begin
                    state_d = ST_DONE;
                end else begin
                    i_d     = i_q - CARD_W'(1);
                    state_d = ST_DRAW;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Deck storage: identity on reset/INIT, pairwise exchange on SWAP
    always_ff @(posedge clk) begin
        if (reset || (state_q == ST_INIT)) begin
            for (int k = 0; k < N_CARDS; k++) begin
                order_q[k] <= CARD_W'(k);
            end
        end else if (state_q == ST_SWAP) begin
            order_q[i_q] <= order_q[j_q];
            order_q[j_q] <= order_q[i_q];
        end
    end

    // Registered read port; out-of-range addresses read as zero
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_card_q <= '0;
        end else if (int'(rd_idx) < N_CARDS) begin
            rd_card_q <= order_q[rd_idx];
        end else begin
            rd_card_q <= '0;
        end
    end

endmodule

// File: tb/tb_card_shuffler.sv
// tb/tb_card_shuffler.sv - self-checking bench for card_shuffler
module tb_card_shuffler;

    logic       clk = 1'b0;
    logic       reset;

    logic       start2, use_seed2;
    logic [7:0] seed2;
    logic       busy2, done2;
    logic [0:0] rd_idx2, rd_card2;

    logic       start20, use_seed20;
    logic [7:0] seed20;
    logic       busy20, done20;
    logic [4:0] rd_idx20, rd_card20;

    int n_tests = 0;
    int n_fail  = 0;

    int exp_ord  [20];
    int got_ord  [20];
    int save_ord [20];
    int exp_done;
    int draw_cyc [64];

    always #5 clk = ~clk;

    card_shuffler #(.N_CARDS(2)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .use_seed(use_seed2),
        .seed(seed2), .busy(busy2), .done(done2),
        .rd_idx(rd_idx2), .rd_card(rd_card2)
    );

    card_shuffler #(.N_CARDS(20)) dut20 (
        .clk(clk), .reset(reset), .start(start20), .use_seed(use_seed20),
        .seed(seed20), .busy(busy20), .done(done20),
        .rd_idx(rd_idx20), .rd_card(rd_card20)
    );

    function automatic logic [7:0] lstep(input logic [7:0] x);
        return {x[6:0], ^(x & 8'hB8)};
    endfunction

    // Reference: Fisher-Yates over an array, tracking the cycle of each draw
    task automatic model(input logic [7:0] s, input int n);
        logic [7:0] lf;
        int cyc, d, t, nd, mask;
        mask = (n == 2) ? 1 : 31;
        for (int k = 0; k < 20; k++) exp_ord[k] = k;
        lf  = (s == 8'h00) ? 8'hFF : s;
        lf  = lstep(lf);
        cyc = 2;
        nd  = 0;
        for (int i = n - 1; i >= 1; i--) begin
            do begin
                d = int'(lf) & mask;
                if (nd < 64) draw_cyc[nd] = cyc;
                nd++;
                lf = lstep(lf);
                cyc++;
            end while (d > i);
            t          = exp_ord[i];
            exp_ord[i] = exp_ord[d];
            exp_ord[d] = t;
            lf         = lstep(lf);
            cyc++;
        end
        exp_done = cyc;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_seeded20(input logic [7:0] s);
        start20    = 1'b1;
        use_seed20 = 1'b1;
        seed20     = s;
        step();
        start20    = 1'b0;
    endtask

    task automatic read_order20();
        for (int k = 0; k < 20; k++) begin
            rd_idx20 = 5'(k);
            step();
            got_ord[k] = int'(rd_card20);
        end
    endtask

    // Seeded shuffle: latency, single-cycle done, final order, permutation
    task automatic run_check(input logic [7:0] s, input string tag);
        int c;
        int seen [20];
        int bad;
        model(s, 20);
        start_seeded20(s);
        c = 1;
        while (!done20 && c < 3000) begin
            step();
            c++;
        end
        n_tests++;
        if (c !== exp_done) begin
            n_fail++;
            $display("FAIL %s done_cycle seed=%02h: got %0d expected %0d", tag, s, c, exp_done);
        end
        step();
        n_tests++;
        if (done20 !== 1'b0 || busy20 !== 1'b0) begin
            n_fail++;
            $display("FAIL %s after_done seed=%02h: got done=%b busy=%b expected 0 0", tag, s, done20, busy20);
        end
        read_order20();
        bad = 0;
        for (int k = 0; k < 20; k++) if (got_ord[k] !== exp_ord[k]) bad++;
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL %s order seed=%02h: got %0d wrong entries expected 0", tag, s, bad);
        end
        for (int k = 0; k < 20; k++) seen[k] = 0;
        for (int k = 0; k < 20; k++) if (got_ord[k] >= 0 && got_ord[k] < 20) seen[got_ord[k]]++;
        bad = 0;
        for (int k = 0; k < 20; k++) if (seen[k] != 1) bad++;
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL %s permutation seed=%02h: got %0d values not seen once expected 0", tag, s, bad);
        end
    endtask

    task automatic test_reset();
        int bad;
        reset = 1'b1;
        repeat (2) step();
        n_tests++;
        if (busy20 !== 1'b0 || done20 !== 1'b0 || rd_card20 !== 5'd0 || busy2 !== 1'b0 || done2 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got busy=%b done=%b rd=%0d expected 0 0 0", busy20, done20, rd_card20);
        end
        n_tests++;
        if (dut20.u_lfsr.state_o !== 8'hFF) begin
            n_fail++;
            $display("FAIL reset_lfsr: got %02h expected ff", dut20.u_lfsr.state_o);
        end
        reset = 1'b0;
        read_order20();
        bad = 0;
        for (int k = 0; k < 20; k++) if (got_ord[k] !== k) bad++;
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL reset_order: got %0d non-identity entries expected 0", bad);
        end
    endtask

    task automatic test_lfsr_step();
        logic [7:0] exp_l [5];
        exp_l[0] = 8'h01; exp_l[1] = 8'h02; exp_l[2] = 8'h04; exp_l[3] = 8'h08; exp_l[4] = 8'h11;
        start2    = 1'b1;
        use_seed2 = 1'b1;
        seed2     = 8'h01;
        step();
        start2    = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            n_tests++;
            if (dut2.u_lfsr.state_o !== exp_l[c-1]) begin
                n_fail++;
                $display("FAIL lfsr_step c=%0d: got %02h expected %02h", c, dut2.u_lfsr.state_o, exp_l[c-1]);
            end
            n_tests++;
            if (done2 !== (c == 4)) begin
                n_fail++;
                $display("FAIL n2_done c=%0d: got %b expected %b", c, done2, (c == 4));
            end
            step();
        end
        rd_idx2 = 1'b0;
        step();
        n_tests++;
        if (rd_card2 !== 1'b1) begin
            n_fail++;
            $display("FAIL n2_order0: got %0d expected 1", rd_card2);
        end
        rd_idx2 = 1'b1;
        step();
        n_tests++;
        if (rd_card2 !== 1'b0) begin
            n_fail++;
            $display("FAIL n2_order1: got %0d expected 0", rd_card2);
        end
    endtask

    task automatic test_permutation();
        for (int t = 0; t < 50; t++) begin
            run_check(8'($urandom), "perm");
        end
    endtask

    task automatic test_determinism();
        int bad;
        run_check(8'h5A, "det5a_a");
        for (int k = 0; k < 20; k++) save_ord[k] = got_ord[k];
        repeat (7) step();
        run_check(8'h5A, "det5a_b");
        bad = 0;
        for (int k = 0; k < 20; k++) if (got_ord[k] !== save_ord[k]) bad++;
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL det_same_seed: got %0d differing entries expected 0", bad);
        end
        run_check(8'h00, "det_zero");
        for (int k = 0; k < 20; k++) save_ord[k] = got_ord[k];
        run_check(8'hFF, "det_ff");
        bad = 0;
        for (int k = 0; k < 20; k++) if (got_ord[k] !== save_ord[k]) bad++;
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL det_zero_vs_ff: got %0d differing entries expected 0", bad);
        end
    endtask

    task automatic test_handshake();
        int c, nd, first, bad;
        logic [7:0] s;
        s = 8'h37;
        model(s, 20);
        start_seeded20(s);
        c = 1; nd = 0; first = -1;
        while (c < exp_done + 20) begin
            if (done20) begin
                nd++;
                if (first < 0) first = c;
            end
            if (c == 5) begin
                start20 = 1'b1;
                seed20  = s ^ 8'h3C;
            end else begin
                start20 = 1'b0;
            end
            step();
            c++;
        end
        start20 = 1'b0;
        n_tests++;
        if (nd != 1 || first != exp_done) begin
            n_fail++;
            $display("FAIL busy_start_ignored: got %0d dones first at %0d expected 1 at %0d", nd, first, exp_done);
        end
        read_order20();
        bad = 0;
        for (int k = 0; k < 20; k++) if (got_ord[k] !== exp_ord[k]) bad++;
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL busy_start_order: got %0d wrong entries expected 0", bad);
        end
    endtask

    task automatic test_back_to_back();
        int c, nd, d1, d2, bad;
        logic [7:0] s;
        s = 8'hA6;
        model(s, 20);
        start20    = 1'b1;
        use_seed20 = 1'b1;
        seed20     = s;
        step();
        c = 1; nd = 0; d1 = -1; d2 = -1;
        while (c <= 2 * exp_done + 4) begin
            if (done20) begin
                nd++;
                if (d1 < 0) d1 = c; else if (d2 < 0) d2 = c;
            end
            if (c == 2 * exp_done + 1) start20 = 1'b0;
            step();
            c++;
        end
        start20 = 1'b0;
        n_tests++;
        if (nd != 2 || d1 != exp_done || d2 != 2 * exp_done + 1) begin
            n_fail++;
            $display("FAIL back_to_back: got %0d dones at %0d,%0d expected 2 at %0d,%0d",
                     nd, d1, d2, exp_done, 2 * exp_done + 1);
        end
        n_tests++;
        if (busy20 !== 1'b0) begin
            n_fail++;
            $display("FAIL back_to_back_idle: got busy=%b expected 0", busy20);
        end
        read_order20();
        bad = 0;
        for (int k = 0; k < 20; k++) if (got_ord[k] !== exp_ord[k]) bad++;
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL back_to_back_order: got %0d wrong entries expected 0", bad);
        end
    endtask

    task automatic test_reset_mid_shuffle();
        int c, target, bad;
        logic [7:0] s;
        s = 8'hC3;
        model(s, 20);
        target = draw_cyc[4];
        start_seeded20(s);
        c = 1;
        while (c < target) begin
            step();
            c++;
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_tests++;
        if (busy20 !== 1'b0 || done20 !== 1'b0 || rd_card20 !== 5'd0) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: got busy=%b done=%b rd=%0d expected 0 0 0", busy20, done20, rd_card20);
        end
        read_order20();
        bad = 0;
        for (int k = 0; k < 20; k++) if (got_ord[k] !== k) bad++;
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL mid_reset_order: got %0d non-identity entries expected 0", bad);
        end
        run_check(s, "after_reset");
    endtask

    task automatic test_read_latency();
        int a, bad;
        bad = 0;
        for (int t = 0; t < 40; t++) begin
            a = int'($urandom_range(0, 19));
            rd_idx20 = 5'(a);
            step();
            if (int'(rd_card20) !== exp_ord[a]) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL read_latency: got %0d wrong reads expected 0", bad);
        end
    endtask

    initial begin
        reset      = 1'b1;
        start2     = 1'b0; use_seed2  = 1'b0; seed2  = 8'h00; rd_idx2  = 1'b0;
        start20    = 1'b0; use_seed20 = 1'b0; seed20 = 8'h00; rd_idx20 = 5'd0;
        test_reset();
        test_lfsr_step();
        test_permutation();
        test_determinism();
        test_handshake();
        test_back_to_back();
        test_reset_mid_shuffle();
        test_read_latency();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
